fas_serial_ctrl: RTL and testbench
==================================

# fas_serial_ctrl

Bit-serial add/subtract controller that sequences a single 1-bit `fas` full adder/subtractor cell over W-bit operands, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/done handshake. It turns the combinational `fas` cell into a multi-cycle W-bit arithmetic unit for the surrounding datapath.

## Interface
Parameters:
- `W`, 8: operand/result width; legal range 2..32.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only on an edge where `ready`=1.
- `op`  in  1  0 = add (A+B), 1 = subtract (A−B); sampled with `start`.
- `a_in`  in  W  operand A; sampled with `start`.
- `b_in`  in  W  operand B; sampled with `start`.
- `abort`  in  1  synchronous cancel of a running operation.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse; `result` and flags are valid from this cycle on.
- `result`  out  W  sum/difference, held until the next accepted `start`.
- `cout_o`  out  1  final carry (subtract: 1 = no borrow).
- `ovf`  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- `zero`  out  1  `result`==0.

## Operation
- `fas` contract: `a_ns`=0 gives {cout,s}=a+b+cin; `a_ns`=1 gives {cout,s}=a+~b+cin. The controller drives `a_ns`=latched op and `cin`=carry FF.
- States IDLE, RUN, DONE.
- IDLE: `ready`=1. On `start`: load A/B shift regs, latch op, carry FF<=op, bit counter<=0, go to RUN.
- RUN: `fas` sees A[0] and B[0]. Each edge: shift A and B right, shift `s` into the result register MSB (result shifts right), carry FF<=`cout`, counter++. On the edge with counter==W−1: capture the pre-edge carry FF as carry-into-MSB, capture `cout` into `cout_o`, update `ovf` and `zero`, go to DONE.
- DONE: `done`=1 for exactly one cycle, `ready`=0, then IDLE unconditionally.
- `start` while not in IDLE is ignored; it is not queued.
- `abort`=1 in RUN: go to IDLE on the next edge. No `done`. `result` and flags keep their previous completed values; the partial result is discarded through a separate working register. `abort` in IDLE or DONE has no effect.
- Width rules: result is W bits modulo 2^W. Counter is $clog2(W) bits and never wraps past W−1.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `ready`=1, `done`=0, `result`=0, `cout_o`=0, `ovf`=0, `zero`=1, carry FF=0, counter=0. Reset mid-RUN aborts immediately with no `done`.
- Start accepted at edge 0. RUN occupies edges 1..W. `done` is high in the cycle following edge W. `ready` returns in the cycle following edge W+1.
- Throughput: one operation per W+2 cycles. With `start` held high, the next operation is accepted at edge W+2.
- `start` and `abort` on the same edge in IDLE: start wins (abort has no effect in IDLE).
- `done` never coincides with `ready`.

## Structure
- `fas_pkg`: `state_t` enum {IDLE, RUN, DONE}; `OP_ADD`=1'b0, `OP_SUB`=1'b1.
- One sub-module: the existing `fas` cell, instantiated once as `u_fas`. All sequencing stays in `fas_serial_ctrl`.

## Test plan
- W=8, op=0, A=8'h35, B=8'h4A -> `done` in the cycle after edge 8; result=8'h7F, `cout_o`=0, `ovf`=0, `zero`=0.
- op=1, A=8'h80, B=8'h01 -> result=8'h7F, `cout_o`=1, `ovf`=1. Then op=1, A=8'h05, B=8'h07 -> result=8'hFE, `cout_o`=0, `ovf`=0.
- op=0, A=8'hFF, B=8'h01 -> result=8'h00, `cout_o`=1, `zero`=1, `ovf`=0. Then op=0, A=8'h7F, B=8'h01 -> 8'h80, `ovf`=1.
- `start` held high continuously with changing operands -> accepts only at edges 0, 10, 20; `ready` is low in between; each `done` is a single cycle.
- A previous result of 8'h7F, then a new start and `abort` at RUN edge 3 -> IDLE at the next edge, no `done`, result stays 8'h7F.
- `rst_n` dropped mid-RUN -> outputs go to reset values immediately (no clock needed); a fresh op after release completes normally.

Source files
------------

// File: rtl/fas_pkg.sv
// fas_pkg: shared types and constants for the bit-serial add/subtract
// controller and its interface.
//   state_t : controller FSM states (IDLE, RUN, DONE)
//   OP_ADD  : op encoding for A+B
//   OP_SUB  : op encoding for A-B
package fas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fas_serial_ctrl_if.sv
// fas_serial_ctrl_if: request/response bundle of the serial add/sub unit.
//   start/op/a_in/b_in/abort : driven by the requester (master)
//   ready/done/result/cout_o/ovf/zero : driven by the controller (slave)
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1; op/a_in/b_in are sampled on that edge only. done pulses for one
// cycle when result and flags become valid; they hold until the next accept.
interface fas_serial_ctrl_if #(
  parameter int W = 8
);

  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         abort;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout_o;
  logic         ovf;
  logic         zero;

  modport master (
    output start, op, a_in, b_in, abort,
    input  ready, done, result, cout_o, ovf, zero
  );

  modport slave (
    input  start, op, a_in, b_in, abort,
    output ready, done, result, cout_o, ovf, zero
  );

endinterface

// File: rtl/fas.sv
// fas: 1-bit full adder/subtractor cell.
//   a, b : operand bits
//   cin  : carry in
//   a_ns : 0 -> {cout,s} = a + b + cin ; 1 -> {cout,s} = a + ~b + cin
//   s    : sum bit
//   cout : carry out
module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic b_eff;

  assign b_eff = b ^ a_ns;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/fas_serial_ctrl.sv
// fas_serial_ctrl: sequences one fas cell over W-bit operands, LSB first,
// one bit per clock.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request/response bundle (slave side)
//   dbg_state : current FSM state, for observation only
// Latency: accept at edge 0, bit edges 1..W, done in the cycle after edge W,
// ready again in the cycle after edge W+1.
module fas_serial_ctrl
  import fas_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fas_serial_ctrl_if.slave     bus,
  output state_t               dbg_state
);

  localparam int             CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, b_sh_q;
  logic           op_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;
  // Partial sum lives here so an abort never disturbs the published result.
  logic [W-2:0]   work_q;
  logic [W-1:0]   result_q;
  logic           cout_q, ovf_q, zero_q;

  logic           s_bit, c_bit;
  logic [W-1:0]   res_next;

  fas u_fas (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .a_ns (op_q),
    .s    (s_bit),
    .cout (c_bit)
  );

  // On the final bit edge the new sum bit becomes the MSB of the result.
  assign res_next = {s_bit, work_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.abort)          state_d = IDLE;
        else if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q  <= bus.a_in;
            b_sh_q  <= bus.b_in;
            op_q    <= bus.op;
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            carry_q <= bus.op;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (!bus.abort) begin
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            work_q  <= res_next[W-1:1];
            carry_q <= c_bit;
            if (cnt_q == LAST) begin
              result_q <= res_next;
              cout_q   <= c_bit;
              // carry_q still holds the carry into the MSB at this point.
              ovf_q    <= carry_q ^ c_bit;
              zero_q   <= (res_next == '0);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout_o = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fas_serial_ctrl.sv
module tb_fas_serial_ctrl;
  import fas_pkg::*;

  localparam int W  = 8;
  localparam int EW = W + 3;   // {cout, ovf, zero, result}

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  fas_serial_ctrl_if #(.W(W)) bus ();

  fas_serial_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  function automatic logic [EW-1:0] model(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c, v;
    if (op == OP_ADD) full = {1'b0, a} + {1'b0, b};
    else              full = {1'b0, a} + {1'b0, ~b} + 1'b1;
    r = full[W-1:0];
    c = full[W];
    if (op == OP_ADD) v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    else              v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return {c, v, (r == '0), r};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {bus.cout_o, bus.ovf, bus.zero, bus.result};
  endfunction

  task automatic score_done(input string tag);
    check_val({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check_val(tag, observed(), exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check_val("ready_before_start", bus.ready, 1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_val("ready_low_in_run", bus.ready, 0);
  endtask

  // Full operation: start, wait for done with a bound, score, check return to IDLE.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    exp_q.push_back(model(op, a, b));
    start_op(op, a, b);
    k = 0;
    while (!bus.done && k < W + 4) begin
      @(negedge clk);
      k++;
    end
    check_val("latency", k, W);
    if (bus.done) begin
      check_val("done_not_ready", bus.ready, 0);
      score_done("result");
    end
    @(negedge clk);
    check_val("done_one_cycle", bus.done, 0);
    check_val("ready_back", bus.ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc_edges[$];
    logic prev_done;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    #12;
    check_val("rst_ready",  bus.ready, 1);
    check_val("rst_done",   bus.done, 0);
    check_val("rst_flags",  observed(), {1'b0, 1'b0, 1'b1, {W{1'b0}}});
    rst_n = 1'b1;

    // Directed vectors.
    run_op(OP_ADD, 8'h35, 8'h4A);
    check_val("add_35_4a", observed(), {1'b0, 1'b0, 1'b0, 8'h7F});
    run_op(OP_SUB, 8'h80, 8'h01);
    check_val("sub_80_01", observed(), {1'b1, 1'b1, 1'b0, 8'h7F});
    run_op(OP_SUB, 8'h05, 8'h07);
    check_val("sub_05_07", observed(), {1'b0, 1'b0, 1'b0, 8'hFE});
    run_op(OP_ADD, 8'hFF, 8'h01);
    check_val("add_ff_01", observed(), {1'b1, 1'b0, 1'b1, 8'h00});
    run_op(OP_ADD, 8'h7F, 8'h01);
    check_val("add_7f_01", observed(), {1'b0, 1'b1, 1'b0, 8'h80});

    // Randomized operations.
    for (int i = 0; i < 40; i++)
      run_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));

    // start held high: accepts only every W+2 edges.
    prev_done = 1'b0;
    for (int e = 0; e < 3 * (W + 2); e++) begin
      @(negedge clk);
      if (bus.done) begin
        check_val("held_done_pulse", prev_done, 0);
        check_val("held_done_not_ready", bus.ready, 0);
        score_done("held_result");
      end
      prev_done = bus.done;
      bus.start = 1'b1;
      bus.op    = 1'($urandom_range(0, 1));
      bus.a_in  = W'($urandom);
      bus.b_in  = W'($urandom);
      if (bus.ready) begin
        acc_edges.push_back(e);
        exp_q.push_back(model(bus.op, bus.a_in, bus.b_in));
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    for (int e = 0; e < W + 3; e++) begin
      if (bus.done) begin
        check_val("held_done_pulse", prev_done, 0);
        score_done("held_result");
      end
      prev_done = bus.done;
      @(negedge clk);
    end
    check_val("held_accept_count", acc_edges.size(), 3);
    for (int i = 0; i < acc_edges.size(); i++)
      check_val("held_accept_edge", acc_edges[i], i * (W + 2));
    check_val("held_sb_drained", exp_q.size(), 0);

    // Abort mid-run: result keeps its previous completed value.
    run_op(OP_ADD, 8'h35, 8'h4A);
    start_op(OP_SUB, 8'h12, 8'h34);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    check_val("abort_ready", bus.ready, 1);
    check_val("abort_done", bus.done, 0);
    check_val("abort_result", observed(), {1'b0, 1'b0, 1'b0, 8'h7F});
    for (int e = 0; e < W + 2; e++) begin
      @(negedge clk);
      check_val("abort_no_done", bus.done, 0);
    end
    run_op(OP_SUB, 8'h05, 8'h07);

    // Asynchronous reset mid-run.
    start_op(OP_ADD, 8'h7F, 8'h01);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_ready", bus.ready, 1);
    check_val("arst_done", bus.done, 0);
    check_val("arst_flags", observed(), {1'b0, 1'b0, 1'b1, {W{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < W + 2; e++) begin
      @(negedge clk);
      check_val("arst_no_done", bus.done, 0);
    end
    run_op(OP_SUB, 8'h80, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
